// File: rtl/serial_add_pkg.sv
// Shared types and sizing helpers for the bit-serial add/subtract engine.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WIDTH_DEF = 8;

    // Bit-counter width: enough to count 0..w-1, never narrower than one bit.
    function automatic int cnt_w(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell, time-shared by the serial engine.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ cin;
    assign carry = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract engine: one full_adder cell walks the operands
// LSB-first, one bit per clock, behind valid/ready handshakes on both sides.
module serial_adder_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             busy
);

    localparam int CW = cnt_w(WIDTH);

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] opa, opb, sreg;
    logic             carry;
    logic             cout_q, ovf_q;
    logic             fa_sum, fa_carry;
    logic             accept, last;

    // Accept is gated by clr so an abort in IDLE never starts an operation.
    assign accept = in_valid && (state == IDLE) && !clr;
    assign last   = (cnt == CW'(WIDTH - 1));

    full_adder u_fa (
        .a     (opa[0]),
        .b     (opb[0]),
        .cin   (carry),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; clr overrides every transition.
    always_comb begin
        state_nxt = state;
        if (clr) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE:    if (in_valid) state_nxt = RUN;
                RUN:     if (last) state_nxt = DONE;
                DONE:    if (out_ready) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Operand/sum shift registers, carry chain and result flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            opa    <= '0;
            opb    <= '0;
            sreg   <= '0;
            carry  <= 1'b0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (accept) begin
            // Subtract is A + ~B + 1: invert B here and seed the carry with 1.
            cnt   <= '0;
            opa   <= in_a;
            opb   <= in_sub ? ~in_b : in_b;
            sreg  <= '0;
            carry <= in_sub;
        end else if (state == RUN && !clr) begin
            sreg  <= {fa_sum, sreg[WIDTH-1:1]};
            opa   <= {1'b0, opa[WIDTH-1:1]};
            opb   <= {1'b0, opb[WIDTH-1:1]};
            carry <= fa_carry;
            cnt   <= cnt + CW'(1);
            if (last) begin
                // At the MSB, carry is the carry into the sign bit.
                cout_q <= fa_carry;
                ovf_q  <= carry ^ fa_carry;
            end
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == RUN);
    assign out_sum   = sreg;
    assign out_cout  = cout_q;
    assign out_ovf   = ovf_q;

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Bit-serial add/subtract engine that time-shares one 1-bit full_adder cell across all bits of a WIDTH-bit operation.
- Accepts operands over a valid/ready handshake and sequences the cell LSB-first, one bit per clock.
- Presents sum, carry-out and signed overflow over a valid/ready output handshake.
- Sits between a register-file or command front end and any consumer that can tolerate WIDTH-cycle latency in exchange for minimal adder area.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous abort; returns the block to IDLE from any state.
- in_valid  input  1  operand bundle valid.
- in_ready  output  1  block can accept operands.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_sub  input  1  0 = A+B, 1 = A-B (two's complement).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_sum  output  WIDTH  result bits.
- out_cout  output  1  carry-out of MSB; for subtract, 1 = no borrow.
- out_ovf  output  1  signed overflow.
- busy  output  1  high in RUN.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - in_ready=1, out_valid=0, busy=0.
  - out_sum=0, out_cout=0, out_ovf=0.
  - Bit counter, shift registers and carry register all go to 0.
- States: IDLE, RUN, DONE (2-bit encoding).
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: load opA<=in_a and opB<=(in_sub ? ~in_b : in_b).
  - Also load carry<=in_sub, cnt<=0, sum shift register<=0, then go to RUN.
- RUN:
  - in_ready=0, busy=1.
  - Each cycle the full_adder inputs are a=opA[0], b=opB[0], cin=carry.
  - Each edge: sum register shifts right with the cell's sum bit entering at the MSB.
  - Each edge: opA and opB shift right by one (zero fill), carry<=cell carry-out, cnt<=cnt+1.
  - When cnt==WIDTH-1, that edge also captures out_cout<=cell carry-out and out_ovf<=cell carry-in XOR cell carry-out (carry into MSB XOR carry out of MSB), then goes to DONE.
- DONE:
  - out_valid=1, busy=0, in_ready=0.
  - out_sum, out_cout and out_ovf hold stable until out_valid&out_ready.
  - On that handshake edge: go to IDLE and clear out_valid. out_sum, out_cout and out_ovf keep their last values.
- Latency: out_valid rises exactly WIDTH clocks after the accepting edge.
  - Throughput: one operation per WIDTH+2 clocks when out_ready is tied high.
- in_valid is ignored outside IDLE. Operands are captured only at the accept edge; later input changes have no effect.
- clr:
  - Highest priority after reset, in any state.
  - Next edge: IDLE, out_valid=0, busy=0, in_ready=1, and any in-flight or unconsumed result is discarded.
  - clr together with in_valid in IDLE: no accept.
- Counter width is $clog2(WIDTH) bits. The counter never wraps within an operation.
- Operand shift registers zero-fill; no sign extension is needed because exactly WIDTH bits are processed.
- out_cout and out_ovf are valid only while out_valid=1; they are not cleared on the out handshake.

Decomposition:
- Package serial_add_pkg:
  - state typedef (IDLE, RUN, DONE).
  - default WIDTH constant.
  - cnt-width function based on $clog2.
- Sub-module: reuse the existing full_adder cell (ports a, b, cin, sum, carry), instantiated exactly once as the shared datapath.
- All sequencing and registers live in serial_adder_ctrl.

Test Plan:
- Add with exact latency (WIDTH=8): 8'h3C+8'h0F, sub=0 -> out_sum=8'h4B, cout=0, ovf=0; out_valid rises exactly 8 clocks after the accept edge; busy high for exactly 8 cycles.
- Unsigned wrap and signed overflow on add:
  - 8'hFF+8'h01 -> sum=8'h00, cout=1, ovf=0.
  - 8'h7F+8'h01 -> sum=8'h80, cout=0, ovf=1.
- Subtract:
  - 8'h05-8'h07 -> sum=8'hFE, cout=0, ovf=0.
  - 8'h80-8'h01 -> sum=8'h7F, cout=1, ovf=1.
  - 8'h10-8'h10 -> sum=8'h00, cout=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new operands -> outputs stable, in_ready=0, no accept; then out_ready=1 -> IDLE next edge, new operands accepted the following cycle.
- Asynchronous reset mid-RUN: assert rst_n=0 when cnt==3 -> outputs go to their reset values immediately without a clock edge; after release, 8'h01+8'h01 -> 8'h02 with normal latency.
- Abort via clr: assert clr in RUN at cnt==5 -> IDLE next edge with out_valid never asserted. Assert clr in DONE with out_ready=0 -> result dropped and in_ready=1 next edge.
